// File: rtl/usb3_pipe_pkg.sv
// rtl/usb3_pipe_pkg.sv - shared constants and state encoding for the PIPE power controller
package usb3_pipe_pkg;

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    localparam logic [2:0] RXSTAT_RX_PRESENT = 3'b011;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PWR_WAIT   = 2'd1,
        RXDET_WAIT = 2'd2,
        POST       = 2'd3
    } pwr_fsm_e;

endpackage

// File: rtl/usb3_pipe_pwr_ctrl.sv
// rtl/usb3_pipe_pwr_ctrl.sv - PIPE PowerDown and receiver-detect sequencer on the half-rate clock
module usb3_pipe_pwr_ctrl
    import usb3_pipe_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 12500,
    parameter logic [1:0] RESET_PWR      = 2'd2
) (
    input  logic       phy_pipe_half_clk,
    input  logic       reset,
    input  logic       pwr_req,
    input  logic [1:0] pwr_target,
    input  logic       rxdet_req,
    input  logic       tx_elecidle_req,
    input  logic [1:0] phy_phy_status,
    input  logic [5:0] phy_rx_status,
    output logic [1:0] phy_power_down,
    output logic       phy_tx_detrx_lpbk,
    output logic       phy_tx_elecidle,
    output logic [1:0] pwr_state,
    output logic       pwr_ack,
    output logic       rxdet_done,
    output logic       rxdet_present,
    output logic       busy,
    output logic       timeout_err
);

    localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]   TIMER_MAX  = TW'(TIMEOUT_CYCLES);

    pwr_fsm_e      state;
    logic [TW-1:0] timer;
    logic          stat_hit;
    logic [2:0]    stat_code;

    // PhyStatus arrives in two half-rate slots; slot 0 is older and takes precedence
    always_comb begin
        stat_hit  = |phy_phy_status;
        stat_code = phy_phy_status[0] ? phy_rx_status[2:0] : phy_rx_status[5:3];
    end

    assign busy = (state != IDLE);

    // Request sequencing, PHY control outputs and completion pulses
    always_ff @(posedge phy_pipe_half_clk) begin
        if (reset) begin
            state             <= IDLE;
            timer             <= '0;
            phy_power_down    <= RESET_PWR;
            pwr_state         <= RESET_PWR;
            phy_tx_detrx_lpbk <= 1'b0;
            phy_tx_elecidle   <= 1'b1;
            pwr_ack           <= 1'b0;
            rxdet_done        <= 1'b0;
            rxdet_present     <= 1'b0;
            timeout_err       <= 1'b0;
        end else begin
            pwr_ack         <= 1'b0;
            rxdet_done      <= 1'b0;
            timeout_err     <= 1'b0;
            phy_tx_elecidle <= (pwr_state == P0 && state == IDLE) ? tx_elecidle_req : 1'b1;

            case (state)
                IDLE: begin
                    if (pwr_req) begin
                        if (pwr_target == pwr_state) begin
                            pwr_ack <= 1'b1;
                        end else begin
                            phy_power_down <= pwr_target;
                            timer          <= '0;
                            state          <= PWR_WAIT;
                        end
                    end else if (rxdet_req) begin
                        if (pwr_state == P2) begin
                            phy_tx_detrx_lpbk <= 1'b1;
                            timer             <= '0;
                            state             <= RXDET_WAIT;
                        end else begin
                            rxdet_done    <= 1'b1;
                            rxdet_present <= 1'b0;
                        end
                    end
                end

                PWR_WAIT: begin
                    if (stat_hit) begin
                        pwr_state <= phy_power_down;
                        pwr_ack   <= 1'b1;
                        timer     <= '0;
                        state     <= POST;
                    end else if (timer == TIMER_LAST) begin
                        timeout_err    <= 1'b1;
                        phy_power_down <= pwr_state;
                        timer          <= '0;
                        state          <= POST;
                    end else if (timer != TIMER_MAX) begin
                        timer <= timer + TW'(1);
                    end
                end

                RXDET_WAIT: begin
                    if (stat_hit) begin
                        phy_tx_detrx_lpbk <= 1'b0;
                        rxdet_present     <= (stat_code == RXSTAT_RX_PRESENT);
                        rxdet_done        <= 1'b1;
                        timer             <= '0;
                        state             <= POST;
                    end else if (timer == TIMER_LAST) begin
                        phy_tx_detrx_lpbk <= 1'b0;
                        rxdet_present     <= 1'b0;
                        rxdet_done        <= 1'b1;
                        timeout_err       <= 1'b1;
                        timer             <= '0;
                        state             <= POST;
                    end else if (timer != TIMER_MAX) begin
                        timer <= timer + TW'(1);
                    end
                end

                POST: begin
                    timer <= '0;
                    state <= IDLE;
                end

                default: begin
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb3_pipe_pwr_ctrl.sv
// tb/tb_usb3_pipe_pwr_ctrl.sv - directed vector bench for usb3_pipe_pwr_ctrl
module tb_usb3_pipe_pwr_ctrl;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       pwr_req;
    logic [1:0] pwr_target;
    logic       rxdet_req;
    logic       tx_elecidle_req;
    logic [1:0] phy_phy_status;
    logic [5:0] phy_rx_status;
    logic [1:0] phy_power_down;
    logic       phy_tx_detrx_lpbk;
    logic       phy_tx_elecidle;
    logic [1:0] pwr_state;
    logic       pwr_ack;
    logic       rxdet_done;
    logic       rxdet_present;
    logic       busy;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    usb3_pipe_pwr_ctrl #(.TIMEOUT_CYCLES(T), .RESET_PWR(2'd2)) dut (
        .phy_pipe_half_clk (clk),
        .reset             (reset),
        .pwr_req           (pwr_req),
        .pwr_target        (pwr_target),
        .rxdet_req         (rxdet_req),
        .tx_elecidle_req   (tx_elecidle_req),
        .phy_phy_status    (phy_phy_status),
        .phy_rx_status     (phy_rx_status),
        .phy_power_down    (phy_power_down),
        .phy_tx_detrx_lpbk (phy_tx_detrx_lpbk),
        .phy_tx_elecidle   (phy_tx_elecidle),
        .pwr_state         (pwr_state),
        .pwr_ack           (pwr_ack),
        .rxdet_done        (rxdet_done),
        .rxdet_present     (rxdet_present),
        .busy              (busy),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pr;
        logic [1:0] tgt;
        logic       rd;
        logic       eir;
        logic [1:0] st;
        logic [5:0] rx;
        logic [1:0] pd;
        logic       det;
        logic       ei;
        logic [1:0] ps;
        logic       ack;
        logic       done;
        logic       pres;
        logic       bsy;
        logic       terr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic pr, input logic [1:0] tgt, input logic rd, input logic eir,
                       input logic [1:0] st, input logic [5:0] rx,
                       input logic [1:0] pd, input logic det, input logic ei, input logic [1:0] ps,
                       input logic ack, input logic done, input logic pres, input logic bsy,
                       input logic terr);
        vec_t v;
        v.pr = pr; v.tgt = tgt; v.rd = rd; v.eir = eir; v.st = st; v.rx = rx;
        v.pd = pd; v.det = det; v.ei = ei; v.ps = ps; v.ack = ack; v.done = done;
        v.pres = pres; v.bsy = bsy; v.terr = terr;
        tbl.push_back(v);
    endtask

    task automatic chk_idle_p2(input string tag);
        chk({tag, " pd"},    32'(phy_power_down), 32'd2);
        chk({tag, " ps"},    32'(pwr_state), 32'd2);
        chk({tag, " ei"},    32'(phy_tx_elecidle), 32'd1);
        chk({tag, " busy"},  32'(busy), 32'd0);
        chk({tag, " det"},   32'(phy_tx_detrx_lpbk), 32'd0);
        chk({tag, " ack"},   32'(pwr_ack), 32'd0);
        chk({tag, " done"},  32'(rxdet_done), 32'd0);
        chk({tag, " terr"},  32'(timeout_err), 32'd0);
    endtask

    initial begin
        int n;
        int ack_seen;

        reset = 1'b1; pwr_req = 1'b0; pwr_target = 2'd0; rxdet_req = 1'b0;
        tx_elecidle_req = 1'b0; phy_phy_status = 2'b00; phy_rx_status = 6'b0;

        // reset state
        tick(); tick(); tick();
        chk_idle_p2("rst");
        chk("rst pres", 32'(rxdet_present), 32'd0);
        reset = 1'b0;
        tick();
        chk_idle_p2("post_rst");

        // reset in the middle of PWR_WAIT with a PhyStatus in flight
        pwr_req = 1'b1; pwr_target = 2'd0;
        tick();
        chk("midrst enter pd", 32'(phy_power_down), 32'd0);
        chk("midrst enter busy", 32'(busy), 32'd1);
        tick();
        reset = 1'b1; phy_phy_status = 2'b01;
        tick();
        chk_idle_p2("midrst e1");
        pwr_req = 1'b0;
        tick(); tick();
        reset = 1'b0; phy_phy_status = 2'b00;
        tick();
        chk_idle_p2("midrst after");

        //   pr tgt rd eir st     rx          pd det ei ps ack dn pr bsy te
        add(0, 0, 0, 0, 2'b00, 6'b000000,   2, 0, 1, 2, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 2'b00, 6'b000000,   0, 0, 1, 2, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 2'b00, 6'b000000,   0, 0, 1, 2, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 2'b00, 6'b000000,   0, 0, 1, 2, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 2'b00, 6'b000000,   0, 0, 1, 2, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 2'b00, 6'b000000,   0, 0, 1, 2, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 2'b10, 6'b000000,   0, 0, 1, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 2'b00, 6'b000000,   0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 6'b000000,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 2'b00, 6'b000000,   0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 6'b000000,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        // receiver detect in P0: immediate done, never touches the PHY
        add(0, 0, 1, 0, 2'b00, 6'b000000,   0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 6'b000000,   0, 0, 0, 0, 0, 0, 0, 0, 0);
        // back to P2
        add(1, 2, 0, 0, 2'b00, 6'b000000,   2, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 2, 0, 0, 2'b01, 6'b000000,   2, 0, 1, 2, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 2'b00, 6'b000000,   2, 0, 1, 2, 0, 0, 0, 0, 0);
        // detect, slot 0 reports present
        add(0, 0, 1, 0, 2'b00, 6'b000000,   2, 1, 1, 2, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 2'b00, 6'b000000,   2, 1, 1, 2, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 2'b01, 6'b000011,   2, 0, 1, 2, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 2'b00, 6'b000000,   2, 0, 1, 2, 0, 0, 1, 0, 0);
        // both slots: slot 0 = 000 wins over slot 1 = 011
        add(0, 0, 1, 0, 2'b00, 6'b000000,   2, 1, 1, 2, 0, 0, 1, 1, 0);
        add(0, 0, 1, 0, 2'b11, 6'b011000,   2, 0, 1, 2, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 2'b00, 6'b000000,   2, 0, 1, 2, 0, 0, 0, 0, 0);
        // slot 1 only, present
        add(0, 0, 1, 0, 2'b00, 6'b000000,   2, 1, 1, 2, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 2'b10, 6'b011000,   2, 0, 1, 2, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 2'b00, 6'b000000,   2, 0, 1, 2, 0, 0, 1, 0, 0);
        // slot 1 only, slot 0 field ignored
        add(0, 0, 1, 0, 2'b00, 6'b000000,   2, 1, 1, 2, 0, 0, 1, 1, 0);
        add(0, 0, 1, 0, 2'b10, 6'b000011,   2, 0, 1, 2, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 2'b00, 6'b000000,   2, 0, 1, 2, 0, 0, 0, 0, 0);
        // pwr_req (same target) and rxdet_req together
        add(1, 2, 1, 0, 2'b00, 6'b000000,   2, 0, 1, 2, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 2'b00, 6'b000000,   2, 1, 1, 2, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 2'b11, 6'b000011,   2, 0, 1, 2, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 2'b00, 6'b000000,   2, 0, 1, 2, 0, 0, 1, 0, 0);

        foreach (tbl[i]) begin
            pwr_req = tbl[i].pr; pwr_target = tbl[i].tgt; rxdet_req = tbl[i].rd;
            tx_elecidle_req = tbl[i].eir; phy_phy_status = tbl[i].st; phy_rx_status = tbl[i].rx;
            tick();
            chk($sformatf("row%0d pd", i),   32'(phy_power_down),    32'(tbl[i].pd));
            chk($sformatf("row%0d det", i),  32'(phy_tx_detrx_lpbk), 32'(tbl[i].det));
            chk($sformatf("row%0d ei", i),   32'(phy_tx_elecidle),   32'(tbl[i].ei));
            chk($sformatf("row%0d ps", i),   32'(pwr_state),         32'(tbl[i].ps));
            chk($sformatf("row%0d ack", i),  32'(pwr_ack),           32'(tbl[i].ack));
            chk($sformatf("row%0d done", i), 32'(rxdet_done),        32'(tbl[i].done));
            chk($sformatf("row%0d pres", i), 32'(rxdet_present),     32'(tbl[i].pres));
            chk($sformatf("row%0d busy", i), 32'(busy),              32'(tbl[i].bsy));
            chk($sformatf("row%0d terr", i), 32'(timeout_err),       32'(tbl[i].terr));
        end

        // power change to P3 with no PhyStatus: timeout after exactly T cycles
        pwr_req = 1'b1; pwr_target = 2'd3; phy_phy_status = 2'b00;
        tick();
        chk("pto enter pd", 32'(phy_power_down), 32'd3);
        ack_seen = 0;
        n = T + 5;
        for (int k = 1; k <= T + 4; k++) begin
            tick();
            if (pwr_ack) ack_seen++;
            if (timeout_err) begin
                n = k;
                break;
            end
        end
        chk("pto latency", 32'(n), 32'(T));
        chk("pto pd revert", 32'(phy_power_down), 32'd2);
        chk("pto ps", 32'(pwr_state), 32'd2);
        chk("pto no ack", 32'(ack_seen), 32'd0);
        pwr_req = 1'b0;
        tick();
        chk("pto terr pulse", 32'(timeout_err), 32'd0);
        chk("pto idle", 32'(busy), 32'd0);

        // receiver detect with no PhyStatus: timeout clears present
        rxdet_req = 1'b1;
        tick();
        chk("rto det", 32'(phy_tx_detrx_lpbk), 32'd1);
        n = T + 5;
        for (int k = 1; k <= T + 4; k++) begin
            tick();
            if (timeout_err) begin
                n = k;
                break;
            end
        end
        chk("rto latency", 32'(n), 32'(T));
        chk("rto done", 32'(rxdet_done), 32'd1);
        chk("rto pres", 32'(rxdet_present), 32'd0);
        chk("rto det off", 32'(phy_tx_detrx_lpbk), 32'd0);
        rxdet_req = 1'b0;
        tick();
        chk("rto done pulse", 32'(rxdet_done), 32'd0);
        chk("rto idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
